// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: register-access responder on a UART byte stream.
// Ports: main_clk/reset_n, rx_valid/rx_data in, tx_valid/tx_ready/tx_data
// out, reg_addr/reg_wdata/reg_we/reg_re/reg_rdata to the register bank,
// busy, sticky err_timeout/err_overrun.
// Optional: UART_BRIDGE_WRITE_ACK_EN adds an ACK state returning 8'h06.
module uart_reg_bridge #(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int TO_W           = 19
) (
  input  logic       main_clk,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET,
    S_WRITE,
    S_READ,
    S_CAP,
    S_SEND
`ifdef UART_BRIDGE_WRITE_ACK_EN
    ,
    S_ACK
`endif
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      tx_hold;
  logic            tx_fire;
  logic            to_hit;
  logic            rx_drop;

  assign tx_fire = tx_valid & tx_ready;
  assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // Bytes arriving outside IDLE/GET_DATA have nowhere to go.
  assign rx_drop = rx_valid &&
                   (state != S_IDLE) &&
                   (state != S_GET);

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (rx_valid)
          state_nx = rx_data[7] ? S_GET : S_READ;
      // A data byte on the expiry cycle wins over the timeout.
      S_GET:
        if (rx_valid)    state_nx = S_WRITE;
        else if (to_hit) state_nx = S_IDLE;
`ifdef UART_BRIDGE_WRITE_ACK_EN
      S_WRITE: state_nx = S_ACK;
      S_ACK:   if (tx_fire) state_nx = S_IDLE;
`else
      S_WRITE: state_nx = S_IDLE;
`endif
      S_READ:  state_nx = S_CAP;
      S_CAP:   state_nx = S_SEND;
      S_SEND:  if (tx_fire) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    reg_we   = 1'b0;
    reg_re   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = tx_hold;
    unique case (state)
      S_WRITE: reg_we = 1'b1;
      S_READ:  reg_re = 1'b1;
      S_SEND:  tx_valid = 1'b1;
`ifdef UART_BRIDGE_WRITE_ACK_EN
      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = 8'h06;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_addr    <= '0;
      reg_wdata   <= '0;
      tx_hold     <= '0;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (state == S_IDLE && rx_valid)
        reg_addr <= rx_data[6:0];
      // Cleared while idle so GET_DATA always starts from zero.
      if (state == S_IDLE)
        to_cnt <= '0;
      else if (state == S_GET && to_cnt != '1)
        to_cnt <= to_cnt + TO_W'(1);
      if (state == S_GET && rx_valid)
        reg_wdata <= rx_data;
      if (state == S_GET && !rx_valid && to_hit)
        err_timeout <= 1'b1;
      if (state == S_CAP)
        tx_hold <= reg_rdata;
      if (rx_drop)
        err_overrun <= 1'b1;
    end
  end

endmodule
